mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; DEPTH, 256, memory words; CNT_W, 16, performance-counter width.
REQ-002 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, reset; SHALL be asynchronous and active-low.
REQ-004 Ports req_valid[1:0], input, 2, per-slot request valid (slot 0, slot 1).
REQ-005 Ports req_ready[1:0], output, 2, per-slot grant; a request is accepted on any cycle where req_valid[p] and req_ready[p] are both high.
REQ-006 Ports req_we[1:0], input, 2, 1=store, 0=load.
REQ-007 Ports req_addr0/req_addr1, input, ADDR_W each, word address.
REQ-008 Ports req_wdata0/req_wdata1, input, DATA_W each, store data.
REQ-009 Ports rsp_valid[1:0], output, 2, per-slot response strobe; the block SHALL NOT accept backpressure on responses.
REQ-010 Ports rsp_rdata0/rsp_rdata1, output, DATA_W each, load data.
REQ-011 Ports rsp_err[1:0], output, 2, out-of-range flag, qualified by rsp_valid.
REQ-012 Memory-side outputs, SHALL be: mem_wr_en (1), mem_wr_addr (ADDR_W), mem_data_in (DATA_W), mem_wr_data (DATA_W), mem_rd_en (1), mem_rd_addr (ADDR_W).
REQ-013 Memory-side input mem_data_out, DATA_W, registered read data, valid one cycle after mem_rd_en.
REQ-014 Outputs acc_cnt0/acc_cnt1, CNT_W each, accepted-request counters.

Function
REQ-015 At most one request SHALL be granted per cycle; the grant SHALL be combinational from req_valid and the priority pointer.
REQ-016 Priority SHALL be round-robin: the pointer SHALL move to the non-granted slot after each grant, and SHALL hold when there is no grant.
REQ-017 With only one slot valid, that slot SHALL be granted regardless of the pointer.
REQ-018 An accepted store with addr < DEPTH SHALL drive, in the accept cycle, mem_wr_en=1, mem_wr_addr=addr, and mem_data_in=mem_wr_data=wdata.
REQ-019 An accepted load with addr < DEPTH SHALL drive, in the accept cycle, mem_rd_en=1 and mem_rd_addr=addr.
REQ-020 An accepted request with addr >= DEPTH SHALL NOT assert mem_wr_en or mem_rd_en.
REQ-021 Every accepted request SHALL pulse rsp_valid[p] for exactly one cycle, in the cycle after acceptance (fixed latency 1).
REQ-022 In the response cycle, rsp_err[p] SHALL be 1 if and only if the address was out of range.
REQ-023 rsp_rdata for an in-range load SHALL equal mem_data_out passed through combinationally; rsp_rdata SHALL be 0 for stores, errors and the idle slot.
REQ-024 Response tracking SHALL be a registered record {pend, port, we, err}, updated every cycle.
REQ-025 Back-to-back accepts SHALL be supported with no bubble (full throughput, one request per cycle).
REQ-026 A load accepted the cycle after a store to the same address SHALL return the stored data.
REQ-027 acc_cnt[p] SHALL increment on each accept of slot p and SHALL saturate at all-ones.
REQ-028 Memory-side address and data outputs SHALL be 0 when the corresponding enable is low.

Reset
REQ-029 While rst_n=0, the block SHALL hold: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, all mem_* enables=0, pointer=slot 0, pend=0, acc_cnt=0.
REQ-030 Reset asserted mid-operation SHALL discard any pending response; no rsp_valid SHALL appear after deassertion for pre-reset requests.
REQ-031 The first grant after reset deassertion SHALL be possible in the first clock edge's cycle.

Structure
REQ-032 A shared package SHALL define ADDR_W, DATA_W, DEPTH, the slot-count constant (2) and the response-record struct {pend, port, we, err}.
REQ-033 The round-robin grant plus pointer SHALL be one sub-module, rr_arb2.
REQ-034 The counters and response record SHALL stay in the top level.
REQ-035 The RTL SHALL be synthesizable with no latches.

Verification
REQ-036 Bench: slot 0 stores 0xDEADBEEF to addr 5; slot 0 then loads addr 5 next cycle -> rsp_valid[0] on cycle N+1 (store) and N+2 (load), with rdata=0xDEADBEEF and err=0.
REQ-037 Bench: both slots valid continuously for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; acc_cnt0=acc_cnt1=3.
REQ-038 Bench: slot 1 loads addr 256 -> rsp_valid[1]=1 with rsp_err[1]=1 and rdata=0; mem_rd_en stays 0.
REQ-039 Bench: rst_n dropped in the cycle after a load is accepted -> no rsp_valid after release; counters read 0.
REQ-040 Bench: acc_cnt0 preloaded to 0xFFFE (or CNT_W=2 build) with 3 accepts -> counter holds at all-ones.
REQ-041 Bench: only slot 1 valid while pointer=0 -> slot 1 granted the same cycle; pointer moves to 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants and response record for mem_arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 256;
    localparam int NUM_SLOTS = 2;

    typedef struct packed {
        logic pend;
        logic port;
        logic we;
        logic err;
    } rsp_rec_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-slot round-robin grant with priority pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer lands on the slot that lost (or was not granted) this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-slot memory arbiter with fixed-latency responses
module mem_arbiter
    import mem_arbiter_pkg::NUM_SLOTS, mem_arbiter_pkg::rsp_rec_t;
#(
    parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W = mem_arbiter_pkg::DATA_W,
    parameter int DEPTH  = mem_arbiter_pkg::DEPTH,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SLOTS-1:0] req_valid,
    output logic [NUM_SLOTS-1:0] req_ready,
    input  logic [NUM_SLOTS-1:0] req_we,
    input  logic [ADDR_W-1:0]    req_addr0,
    input  logic [ADDR_W-1:0]    req_addr1,
    input  logic [DATA_W-1:0]    req_wdata0,
    input  logic [DATA_W-1:0]    req_wdata1,
    output logic [NUM_SLOTS-1:0] rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata0,
    output logic [DATA_W-1:0]    rsp_rdata1,
    output logic [NUM_SLOTS-1:0] rsp_err,
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_wr_addr,
    output logic [DATA_W-1:0]    mem_data_in,
    output logic [DATA_W-1:0]    mem_wr_data,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    input  logic [DATA_W-1:0]    mem_data_out,
    output logic [CNT_W-1:0]     acc_cnt0,
    output logic [CNT_W-1:0]     acc_cnt1
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        grant;
    logic              acc;
    logic              sel;
    logic              we;
    logic              in_range;
    logic              wr_go;
    logic              rd_go;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    rsp_rec_t          rec;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign acc       = |grant;
    assign sel       = grant[1];
    assign addr      = sel ? req_addr1 : req_addr0;
    assign wdata     = sel ? req_wdata1 : req_wdata0;
    assign we        = sel ? req_we[1] : req_we[0];
    assign in_range  = {1'b0, addr} < DEPTH_L;
    assign wr_go     = acc & we & in_range;
    assign rd_go     = acc & ~we & in_range;

    // Address/data buses are forced to zero whenever their enable is idle.
    assign mem_wr_en   = wr_go;
    assign mem_wr_addr = wr_go ? addr : '0;
    assign mem_wr_data = wr_go ? wdata : '0;
    assign mem_data_in = mem_wr_data;
    assign mem_rd_en   = rd_go;
    assign mem_rd_addr = rd_go ? addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec <= '0;
        end else begin
            rec <= '{pend: acc, port: sel, we: we, err: ~in_range};
        end
    end

    // Read data comes straight from the registered memory port in the response cycle.
    always_comb begin
        rsp_valid  = '0;
        rsp_err    = '0;
        rsp_rdata0 = '0;
        rsp_rdata1 = '0;
        if (rec.pend) begin
            rsp_valid[rec.port] = 1'b1;
            rsp_err[rec.port]   = rec.err;
            if (!rec.we && !rec.err) begin
                if (rec.port) begin
                    rsp_rdata1 = mem_data_out;
                end else begin
                    rsp_rdata0 = mem_data_out;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt0 <= '0;
            acc_cnt1 <= '0;
        end else begin
            if (grant[0] && (acc_cnt0 != '1)) begin
                acc_cnt0 <= acc_cnt0 + CNT_W'(1);
            end
            if (grant[1] && (acc_cnt1 != '1)) begin
                acc_cnt1 <= acc_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_we, req_ready, rsp_valid, rsp_err;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [31:0] rsp_rdata0, rsp_rdata1;
    logic        mem_wr_en, mem_rd_en;
    logic [31:0] mem_wr_addr, mem_data_in, mem_wr_data, mem_rd_addr;
    logic [31:0] mem_data_out;
    logic [15:0] acc_cnt0, acc_cnt1;

    logic [1:0]  s_req_valid, s_req_ready, s_rsp_valid, s_rsp_err;
    logic [31:0] s_rsp_rdata0, s_rsp_rdata1;
    logic        s_mem_wr_en, s_mem_rd_en;
    logic [31:0] s_mem_wr_addr, s_mem_data_in, s_mem_wr_data, s_mem_rd_addr;
    logic [1:0]  s_acc_cnt0, s_acc_cnt1;

    logic [31:0] mem [0:255];

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_rdata0(rsp_rdata0), .rsp_rdata1(rsp_rdata1),
        .rsp_err(rsp_err),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_data_in(mem_data_in),
        .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_data_out(mem_data_out),
        .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1)
    );

    mem_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(2'b00),
        .req_addr0(32'd0), .req_addr1(32'd0),
        .req_wdata0(32'd0), .req_wdata1(32'd0),
        .rsp_valid(s_rsp_valid), .rsp_rdata0(s_rsp_rdata0), .rsp_rdata1(s_rsp_rdata1),
        .rsp_err(s_rsp_err),
        .mem_wr_en(s_mem_wr_en), .mem_wr_addr(s_mem_wr_addr), .mem_data_in(s_mem_data_in),
        .mem_wr_data(s_mem_wr_data), .mem_rd_en(s_mem_rd_en), .mem_rd_addr(s_mem_rd_addr),
        .mem_data_out(32'd0),
        .acc_cnt0(s_acc_cnt0), .acc_cnt1(s_acc_cnt1)
    );

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr[7:0]] <= mem_wr_data;
        if (mem_rd_en) mem_data_out <= mem[mem_rd_addr[7:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input int port, input logic err, input logic [31:0] rd);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rd;
        sbq.push_back(e);
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1);
        req_valid  = v;
        req_we     = we;
        req_addr0  = a0;
        req_addr1  = a1;
        req_wdata0 = w0;
        req_wdata1 = w1;
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rsp_valid[p]) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("unexpected_rsp%0d", p), 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rsp_port", p, e.port);
                    chk("rsp_err", rsp_err[p], e.err);
                    chk("rsp_rdata", (p == 1) ? rsp_rdata1 : rsp_rdata0, e.rdata);
                end
            end
        end
    end

    initial begin
        logic [1:0] g;
        rst_n       = 1'b0;
        s_req_valid = 2'b00;
        drive(2'b11, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", req_ready, 2'b00);
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_rsp_err", rsp_err, 2'b00);
        chk("reset_rdata", {rsp_rdata0, rsp_rdata1}, 64'd0);
        chk("reset_mem_en", {mem_wr_en, mem_rd_en}, 2'b00);
        chk("reset_cnt", {acc_cnt0, acc_cnt1}, 32'd0);
        to_next();

        // round-robin stores straight out of reset
        rst_n = 1'b1;
        drive(2'b11, 2'b11, 32'd10, 32'd20, 32'h1010, 32'h2020);
        for (int i = 0; i < 6; i++) begin
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            expect_rsp(i % 2, 1'b0, 32'd0);
            @(negedge clk);
            chk("rr_grant", req_ready, g);
            chk("rr_wr_addr", mem_wr_addr, g[0] ? 32'd10 : 32'd20);
            to_next();
        end
        drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rr_cnt0", acc_cnt0, 16'd3);
        chk("rr_cnt1", acc_cnt1, 16'd3);
        to_next();

        // store then load of the same address
        drive(2'b01, 2'b01, 32'd5, 32'd0, 32'hDEADBEEF, 32'd0);
        expect_rsp(0, 1'b0, 32'd0);
        @(negedge clk);
        chk("st_wr_en", mem_wr_en, 1'b1);
        chk("st_wr_addr", mem_wr_addr, 32'd5);
        chk("st_data_in", mem_data_in, 32'hDEADBEEF);
        chk("st_wr_data", mem_wr_data, 32'hDEADBEEF);
        chk("st_rd_en", mem_rd_en, 1'b0);
        to_next();
        drive(2'b01, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0);
        expect_rsp(0, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        chk("ld_rd_en", mem_rd_en, 1'b1);
        chk("ld_rd_addr", mem_rd_addr, 32'd5);
        chk("ld_idle_wr_bus", {mem_wr_en, mem_wr_addr, mem_wr_data}, 65'd0);
        to_next();

        // out-of-range store and load
        drive(2'b01, 2'b01, 32'd300, 32'd0, 32'h55, 32'd0);
        expect_rsp(0, 1'b1, 32'd0);
        @(negedge clk);
        chk("oor_st_wr_en", mem_wr_en, 1'b0);
        chk("oor_st_wr_data", mem_wr_data, 32'd0);
        to_next();
        drive(2'b10, 2'b00, 32'd0, 32'd256, 32'd0, 32'd0);
        expect_rsp(1, 1'b1, 32'd0);
        @(negedge clk);
        chk("oor_ld_ready", req_ready, 2'b10);
        chk("oor_ld_rd_en", mem_rd_en, 1'b0);
        to_next();

        // lone slot 1 with pointer at 0, then contention shows pointer moved to 0
        drive(2'b10, 2'b00, 32'd0, 32'd20, 32'd0, 32'd0);
        expect_rsp(1, 1'b0, 32'h2020);
        @(negedge clk);
        chk("lone1_ready", req_ready, 2'b10);
        chk("lone1_rd_addr", mem_rd_addr, 32'd20);
        to_next();
        drive(2'b11, 2'b00, 32'd10, 32'd5, 32'd0, 32'd0);
        expect_rsp(0, 1'b0, 32'h1010);
        @(negedge clk);
        chk("ptr0_grant", req_ready, 2'b01);
        to_next();
        expect_rsp(1, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        chk("ptr1_grant", req_ready, 2'b10);
        chk("ptr1_rd_addr", mem_rd_addr, 32'd5);
        to_next();

        // reset in the cycle after a load is accepted
        drive(2'b01, 2'b00, 32'd10, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("pre_rst_grant", req_ready, 2'b01);
        to_next();
        drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
        chk("mid_rst_cnt", {acc_cnt0, acc_cnt1}, 32'd0);
        to_next();
        to_next();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", rsp_valid, 2'b00);
            to_next();
        end
        chk("post_rst_cnt", {acc_cnt0, acc_cnt1}, 32'd0);

        // saturation on the narrow-counter instance
        s_req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            to_next();
            @(negedge clk);
            chk("sat_cnt0", s_acc_cnt0, (i + 1 > 3) ? 2'd3 : 2'(i + 1));
        end
        s_req_valid = 2'b00;
        to_next();
        to_next();

        chk("sb_empty", sbq.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
